seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounced capture of a multiplexed 7-segment scan into a decoded digit frame.
// Optional saturating error counter on oERRCNT when SEG7_SCAN_DECODER_ERRCNT_EN is defined.
module seg7_scan_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int NDIG = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [6:0]        iSEG,
  input  logic [NDIG-1:0]   iSEL,
  input  logic              iACK,
  output logic [4*NDIG-1:0] oDIG,
  output logic              oVALID,
  output logic              oERR,
  output logic              oOVR,
  output logic [7:0]        oERRCNT
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [7:0] SC = STABLE_CYC[7:0];
  typedef enum logic [1:0] {WAIT_SEL, FILTER, HOLD} state_t;
  state_t state_q, state_d;
  logic [6:0] seg_m_q, seg_s_q, pat_q, pat_d;
  logic [NDIG-1:0] sel_m_q, sel_s_q, lsel_q, lsel_d, seen_q, seen_d;
  logic [IW-1:0] idx_q, idx_d, sel_idx;
  logic [7:0] cnt_q, cnt_d;
  logic [4*NDIG-1:0] slot_q, slot_d, dig_q, dig_d;
  logic valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
  logic onehot, wr, done;
  logic [3:0] code;

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = 4'h0;
      7'b1111001: decode = 4'h1;
      7'b0100100: decode = 4'h2;
      7'b0110000: decode = 4'h3;
      7'b0011001: decode = 4'h4;
      7'b0010010: decode = 4'h5;
      7'b0000010: decode = 4'h6;
      7'b1111000: decode = 4'h7;
      7'b0000000: decode = 4'h8;
      7'b0011000: decode = 4'h9;
      7'b1111111: decode = 4'hA;
      7'b0100011: decode = 4'hB;
      7'b0111111: decode = 4'hF;
      default:    decode = 4'hE;
    endcase
  endfunction

  assign onehot = $onehot(sel_s_q);
  assign code = decode(pat_q);
  assign done = &seen_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) if (sel_s_q[i]) sel_idx = IW'(i);
  end

  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    lsel_d = lsel_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    wr = 1'b0;
    case (state_q)
      WAIT_SEL: if (onehot) begin
        pat_d = seg_s_q;
        lsel_d = sel_s_q;
        idx_d = sel_idx;
        cnt_d = '0;
        state_d = FILTER;
      end
      FILTER: if (sel_s_q != lsel_q) state_d = WAIT_SEL;
      else if (seg_s_q != pat_q) begin
        pat_d = seg_s_q;
        cnt_d = '0;
      end else begin
        cnt_d = (cnt_q == SC) ? SC : cnt_q + 8'd1;
        wr = (cnt_d == SC);
        state_d = wr ? HOLD : FILTER;
      end
      HOLD: state_d = (sel_s_q != lsel_q) ? WAIT_SEL : HOLD;
      default: state_d = WAIT_SEL;
    endcase
  end

  // A completed frame is moved out (or dropped) the cycle after its last seen bit lands.
  always_comb begin
    seen_d = done ? '0 : seen_q;
    slot_d = slot_q;
    if (wr) begin
      seen_d[idx_q] = 1'b1;
      slot_d[4*idx_q +: 4] = code;
    end
    err_d = wr && (code == 4'hE);
    dig_d = (done && (!valid_q || iACK)) ? slot_q : dig_q;
    valid_d = done ? 1'b1 : (valid_q && !iACK);
    ovr_d = ovr_q || (done && valid_q && !iACK);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      seg_m_q <= '0;
      seg_s_q <= '0;
      sel_m_q <= '0;
      sel_s_q <= '0;
      state_q <= WAIT_SEL;
      pat_q <= '0;
      lsel_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      seen_q <= '0;
      slot_q <= '0;
      dig_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      seg_m_q <= iSEG;
      seg_s_q <= seg_m_q;
      sel_m_q <= iSEL;
      sel_s_q <= sel_m_q;
      state_q <= state_d;
      pat_q <= pat_d;
      lsel_q <= lsel_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      slot_q <= slot_d;
      dig_q <= dig_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
    end
  end

  assign oDIG = dig_q;
  assign oVALID = valid_q;
  assign oERR = err_q;
  assign oOVR = ovr_q;

`ifdef SEG7_SCAN_DECODER_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  assign errcnt_d = (err_d && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) errcnt_q <= '0;
    else errcnt_q <= errcnt_d;
  end
  assign oERRCNT = errcnt_q;
`else
  assign oERRCNT = '0;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: randomized scan stimulus checked against a frame-level reference model.
module tb_seg7_scan_decoder;
  logic clk = 0, rst_n = 0, iACK = 0;
  logic [6:0] iSEG = 7'h7F;
  logic [3:0] iSEL = '0;
  logic [15:0] oDIG;
  logic oVALID, oERR, oOVR;
  logic [7:0] oERRCNT;
  int n_cmp = 0, n_bad = 0, err_seen = 0;

  seg7_scan_decoder dut (
    .iCLK(clk), .iRST_N(rst_n), .iSEG(iSEG), .iSEL(iSEL), .iACK(iACK),
    .oDIG(oDIG), .oVALID(oVALID), .oERR(oERR), .oOVR(oOVR), .oERRCNT(oERRCNT)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (oERR === 1'b1) err_seen++;

  logic [6:0] vpat [13] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000, 7'b1111111, 7'b0100011, 7'b0111111};
  logic [3:0] vcode [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
  logic [6:0] bad_pat = 7'b1010101;

  logic [15:0] m_slot, m_dig;
  logic [3:0] m_seen;
  logic m_valid, m_ovr;
  int m_errs, m_err_total = 0;

  function automatic logic [3:0] ref_code(input logic [6:0] p);
    ref_code = 4'hE;
    for (int i = 0; i < 13; i++) if (vpat[i] == p) ref_code = vcode[i];
  endfunction

  function automatic logic [7:0] exp_errcnt();
`ifdef SEG7_SCAN_DECODER_ERRCNT_EN
    exp_errcnt = (m_errs > 255) ? 8'd255 : 8'(m_errs);
`else
    exp_errcnt = 8'd0;
`endif
  endfunction

  function automatic void model_reset();
    m_slot = '0; m_dig = '0; m_seen = '0; m_valid = 0; m_ovr = 0; m_errs = 0;
  endfunction

  function automatic void model_capture(input int k, input logic [6:0] p);
    logic [3:0] c = ref_code(p);
    m_slot[k*4 +: 4] = c;
    m_seen[k] = 1'b1;
    if (c == 4'hE) begin m_errs++; m_err_total++; end
    if (&m_seen) begin
      m_seen = '0;
      if (!m_valid) begin m_dig = m_slot; m_valid = 1; end
      else m_ovr = 1;
    end
  endfunction

  function automatic logic [6:0] rand_pat();
    rand_pat = ($urandom_range(0, 3) == 0) ? 7'($urandom) : vpat[$urandom_range(0, 12)];
  endfunction

  task automatic strobe(input int k, input logic [6:0] p, input int hold);
    @(negedge clk);
    iSEL = 4'(1 << k);
    iSEG = p;
    repeat (hold - 1) @(negedge clk);
    iSEL = '0;
    iSEG = 7'h7F;
    repeat (4) @(negedge clk);
    if (hold >= 10) model_capture(k, p);
  endtask

  task automatic do_ack();
    @(negedge clk);
    iACK = 1;
    @(negedge clk);
    iACK = 0;
    m_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (oDIG !== 16'h0) begin n_bad++; $display("FAIL reset_dig: got %h want 0000", oDIG); end
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", oVALID); end
    if (oERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", oERR); end
    if (oOVR !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", oOVR); end
    if (oERRCNT !== 8'h0) begin n_bad++; $display("FAIL reset_errcnt: got %h want 00", oERRCNT); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b want 0", oVALID); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) strobe(k, vpat[k+1], 10);
    n_cmp += 4;
    if (oVALID !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", oVALID); end
    if (oDIG !== 16'h4321) begin n_bad++; $display("FAIL basic_dig: got %h want 4321", oDIG); end
    if (err_seen != m_err_total) begin n_bad++; $display("FAIL basic_err: got %0d want %0d", err_seen, m_err_total); end
    if (oOVR !== 1'b0) begin n_bad++; $display("FAIL basic_ovr: got %b want 0", oOVR); end
    do_ack();
    n_cmp++;
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got %b want 0", oVALID); end
  endtask

  task automatic test_short_strobe();
    strobe(0, vpat[$urandom_range(0, 12)], 10);
    strobe(1, vpat[$urandom_range(0, 12)], 10);
    strobe(2, vpat[$urandom_range(0, 12)], 3);
    strobe(3, vpat[$urandom_range(0, 12)], 10);
    n_cmp++;
    if (oVALID !== m_valid) begin n_bad++; $display("FAIL short_no_frame: got %b want %b", oVALID, m_valid); end
    for (int k = 0; k < 4; k++) strobe(k, (k == 2) ? vpat[7] : vpat[$urandom_range(0, 12)], 10);
    n_cmp += 4;
    if (oVALID !== 1'b1) begin n_bad++; $display("FAIL short_valid: got %b want 1", oVALID); end
    if (oDIG[11:8] !== 4'h7) begin n_bad++; $display("FAIL short_nib2: got %h want 7", oDIG[11:8]); end
    if (oDIG !== m_dig) begin n_bad++; $display("FAIL short_dig: got %h want %h", oDIG, m_dig); end
    if (oOVR !== 1'b0) begin n_bad++; $display("FAIL short_ovr: got %b want 0", oOVR); end
    do_ack();
  endtask

  task automatic test_err();
    strobe(0, bad_pat, 10);
    for (int k = 1; k < 4; k++) strobe(k, vpat[$urandom_range(0, 12)], 10);
    n_cmp += 4;
    if (err_seen != m_err_total) begin n_bad++; $display("FAIL err_pulses: got %0d want %0d", err_seen, m_err_total); end
    if (oDIG[3:0] !== 4'hE) begin n_bad++; $display("FAIL err_nib0: got %h want e", oDIG[3:0]); end
    if (oDIG !== m_dig) begin n_bad++; $display("FAIL err_dig: got %h want %h", oDIG, m_dig); end
    if (oERRCNT !== exp_errcnt()) begin n_bad++; $display("FAIL err_cnt1: got %0d want %0d", oERRCNT, exp_errcnt()); end
    do_ack();
    for (int i = 0; i < 300; i++) strobe(0, bad_pat, 10);
    n_cmp += 3;
    if (err_seen != m_err_total) begin n_bad++; $display("FAIL err_pulses300: got %0d want %0d", err_seen, m_err_total); end
    if (oERRCNT !== exp_errcnt()) begin n_bad++; $display("FAIL err_cnt_sat: got %0d want %0d", oERRCNT, exp_errcnt()); end
    if (oVALID !== m_valid) begin n_bad++; $display("FAIL err_valid: got %b want %b", oVALID, m_valid); end
  endtask

  task automatic test_overrun();
    logic [15:0] first;
    do_ack();
    for (int k = 0; k < 4; k++) strobe(k, rand_pat(), 10);
    first = m_dig;
    for (int k = 0; k < 4; k++) strobe(k, rand_pat(), 10);
    n_cmp += 4;
    if (oDIG !== m_dig) begin n_bad++; $display("FAIL ovr_dig: got %h want %h", oDIG, m_dig); end
    if (oDIG !== first) begin n_bad++; $display("FAIL ovr_keep_first: got %h want %h", oDIG, first); end
    if (oOVR !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", oOVR); end
    if (oVALID !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", oVALID); end
    do_ack();
    n_cmp += 2;
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL ovr_ack_valid: got %b want 0", oVALID); end
    if (oOVR !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", oOVR); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) do_ack();
      strobe($urandom_range(0, 3), rand_pat(),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 13));
      n_cmp += 5;
      if (oVALID !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, oVALID, m_valid); end
      if (oDIG !== m_dig) begin n_bad++; $display("FAIL rnd_dig[%0d]: got %h want %h", i, oDIG, m_dig); end
      if (oOVR !== m_ovr) begin n_bad++; $display("FAIL rnd_ovr[%0d]: got %b want %b", i, oOVR, m_ovr); end
      if (err_seen != m_err_total) begin n_bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", i, err_seen, m_err_total); end
      if (oERRCNT !== exp_errcnt()) begin n_bad++; $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", i, oERRCNT, exp_errcnt()); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    iSEL = 4'b0110;
    iSEG = vpat[5];
    repeat (20) @(negedge clk);
    n_cmp++;
    if (oVALID !== m_valid) begin n_bad++; $display("FAIL multihot_valid: got %b want %b", oVALID, m_valid); end
    iSEL = 4'b0010;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    n_cmp += 5;
    if (oDIG !== 16'h0) begin n_bad++; $display("FAIL midrst_dig: got %h want 0000", oDIG); end
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", oVALID); end
    if (oERR !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", oERR); end
    if (oOVR !== 1'b0) begin n_bad++; $display("FAIL midrst_ovr: got %b want 0", oOVR); end
    if (oERRCNT !== 8'h0) begin n_bad++; $display("FAIL midrst_errcnt: got %h want 00", oERRCNT); end
    iSEL = '0;
    iSEG = 7'h7F;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) strobe(k, vpat[$urandom_range(0, 12)], 10);
    n_cmp++;
    if (oVALID !== 1'b0) begin n_bad++; $display("FAIL midrst_partial: got %b want 0", oVALID); end
    strobe(3, vpat[$urandom_range(0, 12)], 10);
    n_cmp += 2;
    if (oVALID !== 1'b1) begin n_bad++; $display("FAIL midrst_frame: got %b want 1", oVALID); end
    if (oDIG !== m_dig) begin n_bad++; $display("FAIL midrst_dig2: got %h want %h", oDIG, m_dig); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_strobe();
    test_err();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
